// File: rtl/decode_stage_pkg.sv
// Shared definitions for the decode stage: instruction field layout,
// opcode classes, bubble encoding and the ID/EX register layout.
package decode_stage_pkg;

  localparam int DATA_W    = 16;
  localparam int IMM_W     = 8;
  localparam int ALU_W     = 3;
  localparam int REG_IDX_W = 3;

  // Instruction field bit positions
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 11;
  localparam int CLS_HI = 15;
  localparam int CLS_LO = 14;
  localparam int RD_HI  = 10;
  localparam int RD_LO  = 8;
  localparam int RS2_HI = 7;
  localparam int RS2_LO = 5;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;
  // Opcode bit that carries no meaning in any class
  localparam int IGN_BIT = 13;

  // Instruction word that decodes as a pipeline bubble
  localparam logic [DATA_W-1:0] BUBBLE_WORD = 16'h0000;

  typedef enum logic [1:0] {
    CLS_NOP   = 2'b00,
    CLS_RTYPE = 2'b01,
    CLS_ITYPE = 2'b10,
    CLS_RSVD  = 2'b11
  } op_class_e;

  typedef struct packed {
    logic [DATA_W-1:0]    rc1;
    logic [DATA_W-1:0]    rc2;
    logic [IMM_W-1:0]     imm;
    logic [ALU_W-1:0]     alu_ctrl;
    logic                 alu_src;
    logic                 reg_write;
    logic [REG_IDX_W-1:0] dest;
    logic                 illegal;
  } id_ex_t;

  localparam id_ex_t ID_EX_BUBBLE = '0;

  // ALU operation is the low opcode bits with the ignored bit forced low
  function automatic logic [ALU_W-1:0] alu_op(input logic [DATA_W-1:0] instr);
    logic [ALU_W-1:0] op;
    op = instr[OPC_LO+ALU_W-1:OPC_LO];
    op[IGN_BIT-OPC_LO] = 1'b0;
    return op;
  endfunction

endpackage

// File: rtl/decode_stage_reg_file.sv
// General register file: NUM_REGS x 16-bit, two combinational read ports,
// one synchronous write port with write-first bypass onto both reads.
module reg_file
  import decode_stage_pkg::*;
#(
  parameter int NUM_REGS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_en,
  input  logic [2:0]           wb_addr,
  input  logic [15:0]          wb_data,
  input  logic [2:0]           rs1_addr,
  input  logic [2:0]           rs2_addr,
  output logic [15:0]          rs1_data,
  output logic [15:0]          rs2_data
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  // Next register contents: the addressed entry takes wb_data when enabled
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = (wb_en && (wb_addr == REG_IDX_W'(i))) ? wb_data : regs_q[i];
    end
  end

  // Register storage; reset wins over any write on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= 16'h0000;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read ports: a same-cycle write to the read index is forwarded first
  always_comb begin
    rs1_data = 16'h0000;
    rs2_data = 16'h0000;
    for (int i = 0; i < NUM_REGS; i++) begin
      rs1_data = (rs1_addr == REG_IDX_W'(i)) ? regs_q[i] : rs1_data;
      rs2_data = (rs2_addr == REG_IDX_W'(i)) ? regs_q[i] : rs2_data;
    end
    if (wb_en && (wb_addr == rs1_addr)) begin
      rs1_data = wb_data;
    end else begin
      rs1_data = rs1_data;
    end
    if (wb_en && (wb_addr == rs2_addr)) begin
      rs2_data = wb_data;
    end else begin
      rs2_data = rs2_data;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: field extraction, control decode, register-file
// reads and the ID/EX pipeline register with stall/flush handling.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int          NUM_REGS = 8,
  parameter logic [15:0] NOP_WORD = BUBBLE_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instruction,
  input  logic        stall,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [2:0]  wb_addr,
  input  logic [15:0] wb_data,
  output logic [15:0] register_content1,
  output logic [15:0] register_content2,
  output logic [7:0]  immediate_value,
  output logic [2:0]  alu_control_signal,
  output logic        alu_src_signal,
  output logic        reg_write,
  output logic [2:0]  dest_reg,
  output logic        illegal
);

  logic [REG_IDX_W-1:0] rs1_idx_s;
  logic [REG_IDX_W-1:0] rs2_idx_s;
  logic [DATA_W-1:0]    rs1_data_s;
  logic [DATA_W-1:0]    rs2_data_s;
  op_class_e            op_class_s;
  id_ex_t               dec_s;
  id_ex_t               id_ex_d;
  id_ex_t               id_ex_q;

  assign rs1_idx_s  = instruction[RD_HI:RD_LO];
  assign rs2_idx_s  = instruction[RS2_HI:RS2_LO];
  assign op_class_s = op_class_e'(instruction[CLS_HI:CLS_LO]);

  reg_file #(
    .NUM_REGS(NUM_REGS)
  ) u_reg_file (
    .clk      (clk),
    .rst      (rst),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .rs1_addr (rs1_idx_s),
    .rs2_addr (rs2_idx_s),
    .rs1_data (rs1_data_s),
    .rs2_data (rs2_data_s)
  );

  // Decode the presented instruction into the ID/EX payload
  always_comb begin
    dec_s = ID_EX_BUBBLE;
    if (instruction == NOP_WORD) begin
      dec_s = ID_EX_BUBBLE;
    end else begin
      case (op_class_s)
        CLS_RTYPE: begin
          dec_s.rc1       = rs1_data_s;
          dec_s.rc2       = rs2_data_s;
          dec_s.imm       = instruction[IMM_HI:IMM_LO];
          dec_s.alu_ctrl  = alu_op(instruction);
          dec_s.alu_src   = 1'b0;
          dec_s.reg_write = 1'b1;
          dec_s.dest      = instruction[RD_HI:RD_LO];
          dec_s.illegal   = 1'b0;
        end
        CLS_ITYPE: begin
          dec_s.rc1       = rs1_data_s;
          dec_s.rc2       = rs2_data_s;
          dec_s.imm       = instruction[IMM_HI:IMM_LO];
          dec_s.alu_ctrl  = alu_op(instruction);
          dec_s.alu_src   = 1'b1;
          dec_s.reg_write = 1'b1;
          dec_s.dest      = instruction[RD_HI:RD_LO];
          dec_s.illegal   = 1'b0;
        end
        CLS_RSVD: begin
          // Reserved class behaves as a bubble but flags itself
          dec_s         = ID_EX_BUBBLE;
          dec_s.illegal = 1'b1;
        end
        CLS_NOP: begin
          dec_s = ID_EX_BUBBLE;
        end
        default: begin
          dec_s = ID_EX_BUBBLE;
        end
      endcase
    end
  end

  // ID/EX next state: flush beats stall, stall holds, otherwise capture
  always_comb begin
    id_ex_d = id_ex_q;
    if (flush) begin
      id_ex_d = ID_EX_BUBBLE;
    end else if (stall) begin
      id_ex_d = id_ex_q;
    end else begin
      id_ex_d = dec_s;
    end
  end

  // ID/EX pipeline register with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_ex_q <= ID_EX_BUBBLE;
    end else begin
      id_ex_q <= id_ex_d;
    end
  end

  assign register_content1  = id_ex_q.rc1;
  assign register_content2  = id_ex_q.rc2;
  assign immediate_value    = id_ex_q.imm;
  assign alu_control_signal = id_ex_q.alu_ctrl;
  assign alu_src_signal     = id_ex_q.alu_src;
  assign reg_write          = id_ex_q.reg_write;
  assign dest_reg           = id_ex_q.dest;
  assign illegal            = id_ex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: a reference model predicts the
// ID/EX contents for each driven cycle and queues them for comparison.
module tb_decode_stage;

  logic        clk;
  logic        rst;
  logic [15:0] instruction;
  logic        stall;
  logic        flush;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic [15:0] register_content1;
  logic [15:0] register_content2;
  logic [7:0]  immediate_value;
  logic [2:0]  alu_control_signal;
  logic        alu_src_signal;
  logic        reg_write;
  logic [2:0]  dest_reg;
  logic        illegal;

  typedef struct packed {
    logic [15:0] rc1;
    logic [15:0] rc2;
    logic [7:0]  imm;
    logic [2:0]  alu;
    logic        src;
    logic        rw;
    logic [2:0]  dest;
    logic        ill;
  } exp_t;

  int          n_cmp;
  int          n_err;
  exp_t        sb_q[$];
  exp_t        exp_prev;
  logic [15:0] mregs [8];

  decode_stage dut (
    .clk                (clk),
    .rst                (rst),
    .instruction        (instruction),
    .stall              (stall),
    .flush              (flush),
    .wb_en              (wb_en),
    .wb_addr            (wb_addr),
    .wb_data            (wb_data),
    .register_content1  (register_content1),
    .register_content2  (register_content2),
    .immediate_value    (immediate_value),
    .alu_control_signal (alu_control_signal),
    .alu_src_signal     (alu_src_signal),
    .reg_write          (reg_write),
    .dest_reg           (dest_reg),
    .illegal            (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference decode from the instruction format description
  function automatic exp_t model_decode(input logic [15:0] ins, input logic [15:0] r1, input logic [15:0] r2);
    exp_t e;
    e = '0;
    if (ins != 16'h0000) begin
      if (ins[15:14] == 2'b01 || ins[15:14] == 2'b10) begin
        e.rc1  = r1;
        e.rc2  = r2;
        e.imm  = ins[7:0];
        e.alu  = {1'b0, ins[12:11]};
        e.src  = ins[15];
        e.rw   = 1'b1;
        e.dest = ins[10:8];
      end else if (ins[15:14] == 2'b11) begin
        e.ill = 1'b1;
      end else begin
        e = '0;
      end
    end
    return e;
  endfunction

  task automatic compare_outputs(input string tag, input exp_t e);
    check_eq({tag, ".rc1"},  32'(register_content1),  32'(e.rc1));
    check_eq({tag, ".rc2"},  32'(register_content2),  32'(e.rc2));
    check_eq({tag, ".imm"},  32'(immediate_value),    32'(e.imm));
    check_eq({tag, ".alu"},  32'(alu_control_signal), 32'(e.alu));
    check_eq({tag, ".src"},  32'(alu_src_signal),     32'(e.src));
    check_eq({tag, ".rw"},   32'(reg_write),          32'(e.rw));
    check_eq({tag, ".dest"}, 32'(dest_reg),           32'(e.dest));
    check_eq({tag, ".ill"},  32'(illegal),            32'(e.ill));
  endtask

  // Drive one cycle, predict the ID/EX result, then compare after the edge
  task automatic drive_cycle(input string tag, input logic [15:0] i_ins, input logic i_stall,
                             input logic i_flush, input logic i_wb_en, input logic [2:0] i_wb_addr,
                             input logic [15:0] i_wb_data);
    exp_t        e;
    logic [15:0] r1;
    logic [15:0] r2;
    instruction = i_ins;
    stall       = i_stall;
    flush       = i_flush;
    wb_en       = i_wb_en;
    wb_addr     = i_wb_addr;
    wb_data     = i_wb_data;
    r1 = (i_wb_en && i_wb_addr == i_ins[10:8]) ? i_wb_data : mregs[i_ins[10:8]];
    r2 = (i_wb_en && i_wb_addr == i_ins[7:5])  ? i_wb_data : mregs[i_ins[7:5]];
    if (i_flush) e = '0;
    else if (i_stall) e = exp_prev;
    else e = model_decode(i_ins, r1, r2);
    sb_q.push_back(e);
    exp_prev = e;
    if (i_wb_en) mregs[i_wb_addr] = i_wb_data;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq({tag, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      compare_outputs(tag, sb_q.pop_front());
    end
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    exp_prev    = '0;
    rst         = 1'b1;
    instruction = 16'h0000;
    stall       = 1'b0;
    flush       = 1'b0;
    wb_en       = 1'b0;
    wb_addr     = 3'd0;
    wb_data     = 16'h0000;
    for (int i = 0; i < 8; i++) mregs[i] = 16'h0000;

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    compare_outputs("reset", '0);
    rst = 1'b0;

    // Write r3 = BEEF, then read it through rs1
    drive_cycle("wb_r3",     16'h0000, 1'b0, 1'b0, 1'b1, 3'd3, 16'hBEEF);
    drive_cycle("rd_r3",     16'h4300, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
    // Same-cycle write to r2 bypassed onto rs2
    drive_cycle("bypass_r2", 16'h4B40, 1'b0, 1'b0, 1'b1, 3'd2, 16'h1234);
    // I-type 10011, imm 7F
    drive_cycle("itype",     16'h997F, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
    // R-type with bit 13 set: ALU op must ignore it
    drive_cycle("bit13",     16'h7A40, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);

    // Stall three cycles while the instruction changes; write proceeds
    drive_cycle("stall0",    16'h8155, 1'b1, 1'b0, 1'b1, 3'd6, 16'hCAFE);
    drive_cycle("stall1",    16'h4B40, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000);
    drive_cycle("stall2",    16'hC000, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000);
    drive_cycle("rd_r6",     16'h46C0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
    // Stall together with flush gives a bubble
    drive_cycle("stall_fl",  16'h997F, 1'b1, 1'b1, 1'b0, 3'd0, 16'h0000);

    // Reserved class: one-cycle illegal pulse, no reg_write
    drive_cycle("illegal",   16'hC123, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
    drive_cycle("ill_clear", 16'h4300, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
    // Illegal held under stall, then cleared by flush
    drive_cycle("ill_again", 16'hD800, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
    drive_cycle("ill_hold",  16'h4300, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000);
    drive_cycle("ill_flush", 16'h4300, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0000);

    // Randomised traffic
    for (int k = 0; k < 60; k++) begin
      drive_cycle("rand", 16'($urandom), ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0),
                  1'($urandom), 3'($urandom), 16'($urandom));
    end

    // Pre-reset reference: r3 still reads back its last value
    drive_cycle("pre_rst",   16'h43A0, 1'b0, 1'b0, 1'b1, 3'd3, 16'hBEEF);
    drive_cycle("pre_rst2",  16'h43A0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);

    // Reset pulsed between edges clears outputs immediately
    instruction = 16'h43A0;
    stall       = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    compare_outputs("rst_async", '0);
    // Write attempted while reset is active must not land
    wb_en   = 1'b1;
    wb_addr = 3'd5;
    wb_data = 16'hAAAA;
    @(posedge clk);
    #1;
    compare_outputs("rst_edge", '0);
    for (int i = 0; i < 8; i++) mregs[i] = 16'h0000;
    exp_prev = '0;
    #2;
    rst   = 1'b0;
    wb_en = 1'b0;
    stall = 1'b0;
    // First capture after reset: r3 and r5 both read zero
    drive_cycle("post_rst",  16'h43A0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);

    if (sb_q.size() != 0) check_eq("sb_leftover", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
